adp_dmem_arbiter: RTL and testbench

Shares the single data-SRAM port between the RV32IMC core's load/store path and ADP debug memory accesses (DEBUG_READ / DEBUG_WRITE). It sits between the core dmem interface, the ADP debug engine and the SRAM macro. In debug mode the system clock is the ADP clock, so the block runs on one clock. Arbitration is round-robin, each granted request is registered onto the SRAM, and a debug-side timeout guarantees the ADP always gets a response.

---
 rtl/adp_dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_adp_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adp_dmem_arbiter.sv
// adp_dmem_arbiter: shares the data-SRAM port between the core load/store
// path and ADP debug memory accesses. Round-robin arbitration, registered
// SRAM request, and a debug-side timeout so the ADP always gets a response.
module adp_dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        adp_tck_i_buf,
    input  logic        adp_trst_i_buf,
    input  logic        adp_debug_mode,
    input  logic [31:0] core_dmem_addr,
    input  logic [3:0]  core_dmem_rmask,
    input  logic [3:0]  core_dmem_wmask,
    input  logic [31:0] core_dmem_wdata,
    output logic [31:0] core_dmem_rdata,
    output logic        core_dmem_resp,
    input  logic        dbg_req_valid,
    input  logic        dbg_req_we,
    input  logic [31:0] dbg_req_addr,
    input  logic [31:0] dbg_req_wdata,
    output logic        dbg_req_ready,
    output logic        dbg_rsp_valid,
    output logic [31:0] dbg_rsp_rdata,
    output logic        dbg_rsp_err,
    output logic [31:0] sram_addr,
    output logic [3:0]  sram_rmask,
    output logic [3:0]  sram_wmask,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_resp
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE_BUSY = 2'd1,
        DBG_BUSY  = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    // Last wait_cnt value before a debug access is declared timed out.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_r;
    logic        last_dbg_r;       // 1: debug was granted last, 0: core
    logic [7:0]  wait_cnt_r;
    logic        dbg_read_r;
    logic [31:0] sram_addr_r;
    logic [31:0] sram_wdata_r;
    logic [3:0]  sram_rmask_r;
    logic [3:0]  sram_wmask_r;
    logic        dbg_rsp_valid_r;
    logic        dbg_rsp_err_r;
    logic [31:0] dbg_rsp_rdata_r;

    logic        core_pend_s;
    logic        dbg_pend_s;
    logic        dbg_win_s;
    logic        core_win_s;
    logic        core_resp_s;

    // Request detection and round-robin decision, only meaningful in IDLE.
    always_comb begin
        core_pend_s = ((core_dmem_rmask | core_dmem_wmask) != 4'h0);
        dbg_pend_s  = dbg_req_valid && adp_debug_mode;
        dbg_win_s   = 1'b0;
        core_win_s  = 1'b0;
        if (state_r == IDLE) begin
            dbg_win_s  = dbg_pend_s && (!core_pend_s || !last_dbg_r);
            core_win_s = core_pend_s && !dbg_win_s;
        end else begin
            dbg_win_s  = 1'b0;
            core_win_s = 1'b0;
        end
        core_resp_s = (state_r == CORE_BUSY) && sram_resp;
    end

    assign dbg_req_ready   = dbg_win_s;
    assign core_dmem_resp  = core_resp_s;
    assign core_dmem_rdata = core_resp_s ? sram_rdata : 32'h0000_0000;
    assign dbg_rsp_valid   = dbg_rsp_valid_r;
    assign dbg_rsp_err     = dbg_rsp_err_r;
    assign dbg_rsp_rdata   = dbg_rsp_rdata_r;
    assign sram_addr       = sram_addr_r;
    assign sram_rmask      = sram_rmask_r;
    assign sram_wmask      = sram_wmask_r;
    assign sram_wdata      = sram_wdata_r;

    // Arbitration FSM: grants, SRAM request registers, timeout and debug response.
    always_ff @(posedge adp_tck_i_buf) begin
        if (adp_trst_i_buf) begin
            state_r         <= IDLE;
            last_dbg_r      <= 1'b1;
            wait_cnt_r      <= 8'd0;
            dbg_read_r      <= 1'b0;
            sram_addr_r     <= 32'h0000_0000;
            sram_wdata_r    <= 32'h0000_0000;
            sram_rmask_r    <= 4'h0;
            sram_wmask_r    <= 4'h0;
            dbg_rsp_valid_r <= 1'b0;
            dbg_rsp_err_r   <= 1'b0;
            dbg_rsp_rdata_r <= 32'h0000_0000;
        end else begin
            // Debug response is a single-cycle pulse.
            dbg_rsp_valid_r <= 1'b0;
            dbg_rsp_err_r   <= 1'b0;
            dbg_rsp_rdata_r <= 32'h0000_0000;
            case (state_r)
                IDLE: begin
                    if (dbg_win_s) begin
                        state_r      <= DBG_BUSY;
                        last_dbg_r   <= 1'b1;
                        wait_cnt_r   <= 8'd0;
                        dbg_read_r   <= !dbg_req_we;
                        sram_addr_r  <= dbg_req_addr;
                        sram_wdata_r <= dbg_req_wdata;
                        sram_rmask_r <= dbg_req_we ? 4'h0 : 4'hF;
                        sram_wmask_r <= dbg_req_we ? 4'hF : 4'h0;
                    end else if (core_win_s) begin
                        state_r      <= CORE_BUSY;
                        last_dbg_r   <= 1'b0;
                        sram_addr_r  <= core_dmem_addr;
                        sram_wdata_r <= core_dmem_wdata;
                        sram_rmask_r <= core_dmem_rmask;
                        sram_wmask_r <= core_dmem_wmask;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CORE_BUSY: begin
                    if (sram_resp) begin
                        state_r      <= IDLE;
                        sram_rmask_r <= 4'h0;
                        sram_wmask_r <= 4'h0;
                    end else begin
                        state_r <= CORE_BUSY;
                    end
                end
                DBG_BUSY: begin
                    if (sram_resp) begin
                        state_r         <= IDLE;
                        sram_rmask_r    <= 4'h0;
                        sram_wmask_r    <= 4'h0;
                        dbg_rsp_valid_r <= 1'b1;
                        dbg_rsp_rdata_r <= dbg_read_r ? sram_rdata : 32'h0000_0000;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        // Give up on the ADP side; keep the SRAM request until it completes.
                        state_r         <= DRAIN;
                        dbg_rsp_valid_r <= 1'b1;
                        dbg_rsp_err_r   <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                DRAIN: begin
                    if (sram_resp) begin
                        state_r      <= IDLE;
                        sram_rmask_r <= 4'h0;
                        sram_wmask_r <= 4'h0;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    sram_rmask_r <= 4'h0;
                    sram_wmask_r <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adp_dmem_arbiter.sv
// Directed bench for adp_dmem_arbiter with a transaction-level reference model
// compared on every falling edge, plus hand-computed literal expectations.
module tb_adp_dmem_arbiter;

    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adp_debug_mode = 1'b0;
    logic [31:0] core_dmem_addr = 32'h0;
    logic [3:0]  core_dmem_rmask = 4'h0;
    logic [3:0]  core_dmem_wmask = 4'h0;
    logic [31:0] core_dmem_wdata = 32'h0;
    logic [31:0] core_dmem_rdata;
    logic        core_dmem_resp;
    logic        dbg_req_valid = 1'b0;
    logic        dbg_req_we = 1'b0;
    logic [31:0] dbg_req_addr = 32'h0;
    logic [31:0] dbg_req_wdata = 32'h0;
    logic        dbg_req_ready;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_rdata;
    logic        dbg_rsp_err;
    logic [31:0] sram_addr;
    logic [3:0]  sram_rmask;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;
    logic        sram_resp = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    adp_dmem_arbiter #(.MAX_WAIT(MW)) dut (
        .adp_tck_i_buf  (clk),
        .adp_trst_i_buf (rst),
        .adp_debug_mode (adp_debug_mode),
        .core_dmem_addr (core_dmem_addr),
        .core_dmem_rmask(core_dmem_rmask),
        .core_dmem_wmask(core_dmem_wmask),
        .core_dmem_wdata(core_dmem_wdata),
        .core_dmem_rdata(core_dmem_rdata),
        .core_dmem_resp (core_dmem_resp),
        .dbg_req_valid  (dbg_req_valid),
        .dbg_req_we     (dbg_req_we),
        .dbg_req_addr   (dbg_req_addr),
        .dbg_req_wdata  (dbg_req_wdata),
        .dbg_req_ready  (dbg_req_ready),
        .dbg_rsp_valid  (dbg_rsp_valid),
        .dbg_rsp_rdata  (dbg_rsp_rdata),
        .dbg_rsp_err    (dbg_rsp_err),
        .sram_addr      (sram_addr),
        .sram_rmask     (sram_rmask),
        .sram_wmask     (sram_wmask),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .sram_resp      (sram_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    logic        m_on = 1'b0;
    logic        m_busy, m_dbg, m_drain, m_last_dbg;
    logic [3:0]  m_rmask, m_wmask;
    logic [31:0] m_addr, m_wdata;
    int          m_age;          // cycles the current SRAM request has been outstanding
    logic        m_rsp_v, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    logic        cp, dp, dwin, cresp;

    initial begin
        forever begin
            @(negedge clk);
            cp    = ((core_dmem_rmask | core_dmem_wmask) != 4'h0);
            dp    = dbg_req_valid && adp_debug_mode;
            dwin  = m_on && !m_busy && dp && (!cp || !m_last_dbg);
            cresp = m_on && m_busy && !m_dbg && sram_resp;
            if (m_on) begin
                chk("m_rmask", 32'(sram_rmask), m_busy ? 32'(m_rmask) : 32'h0);
                chk("m_wmask", 32'(sram_wmask), m_busy ? 32'(m_wmask) : 32'h0);
                if (m_busy) begin
                    chk("m_addr", sram_addr, m_addr);
                    chk("m_wdata", sram_wdata, m_wdata);
                end
                chk("m_ready", 32'(dbg_req_ready), 32'(dwin));
                chk("m_core_resp", 32'(core_dmem_resp), 32'(cresp));
                chk("m_core_rdata", core_dmem_rdata, cresp ? sram_rdata : 32'h0);
                chk("m_rsp_valid", 32'(dbg_rsp_valid), 32'(m_rsp_v));
                if (m_rsp_v) begin
                    chk("m_rsp_err", 32'(dbg_rsp_err), 32'(m_rsp_err));
                    chk("m_rsp_rdata", dbg_rsp_rdata, m_rsp_rdata);
                end
            end
            // advance the model to what holds after the coming rising edge
            if (rst) begin
                m_on = 1'b1; m_busy = 1'b0; m_dbg = 1'b0; m_drain = 1'b0;
                m_last_dbg = 1'b1; m_rmask = 4'h0; m_wmask = 4'h0;
                m_addr = 32'h0; m_wdata = 32'h0; m_age = 0;
                m_rsp_v = 1'b0; m_rsp_err = 1'b0; m_rsp_rdata = 32'h0;
            end else if (m_on) begin
                m_rsp_v = 1'b0; m_rsp_err = 1'b0; m_rsp_rdata = 32'h0;
                if (m_busy && !m_dbg) begin
                    if (sram_resp) m_busy = 1'b0;
                end else if (m_busy && m_drain) begin
                    if (sram_resp) begin m_busy = 1'b0; m_drain = 1'b0; end
                end else if (m_busy) begin
                    if (sram_resp) begin
                        m_busy = 1'b0; m_rsp_v = 1'b1;
                        m_rsp_rdata = (m_rmask != 4'h0) ? sram_rdata : 32'h0;
                    end else if (m_age == MW) begin
                        m_drain = 1'b1; m_rsp_v = 1'b1; m_rsp_err = 1'b1;
                    end else begin
                        m_age++;
                    end
                end else if (dwin) begin
                    m_busy = 1'b1; m_dbg = 1'b1; m_last_dbg = 1'b1; m_age = 1;
                    m_rmask = dbg_req_we ? 4'h0 : 4'hF;
                    m_wmask = dbg_req_we ? 4'hF : 4'h0;
                    m_addr = dbg_req_addr; m_wdata = dbg_req_wdata;
                end else if (cp) begin
                    m_busy = 1'b1; m_dbg = 1'b0; m_last_dbg = 1'b0;
                    m_rmask = core_dmem_rmask; m_wmask = core_dmem_wmask;
                    m_addr = core_dmem_addr; m_wdata = core_dmem_wdata;
                end
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int cnt;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_rmask", 32'(sram_rmask), 32'h0);
        chk("rst_wmask", 32'(sram_wmask), 32'h0);
        chk("rst_addr", sram_addr, 32'h0);
        chk("rst_wdata", sram_wdata, 32'h0);
        chk("rst_core_resp", 32'(core_dmem_resp), 32'h0);
        chk("rst_core_rdata", core_dmem_rdata, 32'h0);
        chk("rst_ready", 32'(dbg_req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(dbg_rsp_valid), 32'h0);
        chk("rst_rsp_rdata", dbg_rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(dbg_rsp_err), 32'h0);

        // core-only read, SRAM answers 2 cycles after masks
        tick();
        core_dmem_addr = 32'h0007_0010; core_dmem_rmask = 4'hF;
        tick();
        chk("cr_rmask", 32'(sram_rmask), 32'hF);
        chk("cr_addr", sram_addr, 32'h0007_0010);
        tick(); tick();
        sram_resp = 1'b1; sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("cr_resp", 32'(core_dmem_resp), 32'h1);
        chk("cr_rdata", core_dmem_rdata, 32'hDEAD_BEEF);
        tick();
        sram_resp = 1'b0; core_dmem_rmask = 4'h0;
        chk("cr_rmask_off", 32'(sram_rmask), 32'h0);
        #1;
        chk("cr_rdata_off", core_dmem_rdata, 32'h0);

        // debug write, SRAM answers immediately
        tick();
        adp_debug_mode = 1'b1; dbg_req_valid = 1'b1; dbg_req_we = 1'b1;
        dbg_req_addr = 32'h0007_0040; dbg_req_wdata = 32'h1234_5678;
        #1;
        chk("dw_ready", 32'(dbg_req_ready), 32'h1);
        tick();
        dbg_req_valid = 1'b0;
        chk("dw_wmask", 32'(sram_wmask), 32'hF);
        chk("dw_wdata", sram_wdata, 32'h1234_5678);
        sram_resp = 1'b1; sram_rdata = 32'h0000_0055;
        tick();
        sram_resp = 1'b0;
        chk("dw_rsp_valid", 32'(dbg_rsp_valid), 32'h1);
        chk("dw_rsp_err", 32'(dbg_rsp_err), 32'h0);
        chk("dw_rsp_rdata", dbg_rsp_rdata, 32'h0);
        tick();
        chk("dw_rsp_pulse", 32'(dbg_rsp_valid), 32'h0);

        // first tie: core wins; core then re-requests at once -> second tie, debug wins
        core_dmem_addr = 32'h0000_0100; core_dmem_rmask = 4'hF;
        dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 32'h0000_0200;
        #1;
        chk("t1_ready", 32'(dbg_req_ready), 32'h0);
        tick();
        chk("t1_addr", sram_addr, 32'h0000_0100);
        sram_resp = 1'b1; sram_rdata = 32'h1111_1111;
        #1;
        chk("t1_core_rdata", core_dmem_rdata, 32'h1111_1111);
        core_dmem_addr = 32'h0000_0104;
        tick();
        sram_resp = 1'b0;
        #1;
        chk("t2_ready", 32'(dbg_req_ready), 32'h1);
        tick();
        dbg_req_valid = 1'b0;
        chk("t2_addr", sram_addr, 32'h0000_0200);
        sram_resp = 1'b1; sram_rdata = 32'h2222_2222;
        tick();
        sram_resp = 1'b0;
        chk("t2_rsp_rdata", dbg_rsp_rdata, 32'h2222_2222);
        tick();
        chk("t3_addr", sram_addr, 32'h0000_0104);
        sram_resp = 1'b1; sram_rdata = 32'h3333_3333;
        #1;
        chk("t3_core_resp", 32'(core_dmem_resp), 32'h1);
        tick();
        sram_resp = 1'b0; core_dmem_rmask = 4'h0;

        // debug mode off: debug ignored, core served back-to-back
        tick();
        adp_debug_mode = 1'b0; dbg_req_valid = 1'b1; dbg_req_we = 1'b1;
        dbg_req_addr = 32'h0000_0900;
        core_dmem_addr = 32'h0000_0400; core_dmem_wmask = 4'h3; core_dmem_wdata = 32'hCAFE_F00D;
        #1;
        chk("off_ready", 32'(dbg_req_ready), 32'h0);
        tick();
        chk("off_wmask", 32'(sram_wmask), 32'h3);
        tick();
        sram_resp = 1'b1; sram_rdata = 32'h0;
        #1;
        chk("off_resp1", 32'(core_dmem_resp), 32'h1);
        core_dmem_wmask = 4'h0; core_dmem_rmask = 4'hC; core_dmem_addr = 32'h0000_0404;
        tick();
        sram_resp = 1'b0;
        #1;
        chk("off_ready2", 32'(dbg_req_ready), 32'h0);
        tick();
        chk("off_rmask2", 32'(sram_rmask), 32'hC);
        sram_resp = 1'b1; sram_rdata = 32'h0BAD_C0DE;
        #1;
        chk("off_rdata2", core_dmem_rdata, 32'h0BAD_C0DE);
        tick();
        sram_resp = 1'b0; core_dmem_rmask = 4'h0; dbg_req_valid = 1'b0; adp_debug_mode = 1'b1;

        // timeout: debug read with no SRAM response
        tick();
        dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 32'h0000_0300;
        #1;
        chk("to_ready", 32'(dbg_req_ready), 32'h1);
        tick();
        dbg_req_valid = 1'b0;
        cnt = 1;
        while (dbg_rsp_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("to_latency", 32'(cnt), 32'd16);
        chk("to_err", 32'(dbg_rsp_err), 32'h1);
        chk("to_rdata", dbg_rsp_rdata, 32'h0);
        chk("to_drain_rmask", 32'(sram_rmask), 32'hF);
        dbg_req_valid = 1'b1; dbg_req_addr = 32'h0000_0700;
        #1;
        chk("to_drain_ready", 32'(dbg_req_ready), 32'h0);
        tick();
        chk("to_no_repeat", 32'(dbg_rsp_valid), 32'h0);
        dbg_req_valid = 1'b0;
        sram_resp = 1'b1; sram_rdata = 32'hAAAA_5555;
        tick();
        sram_resp = 1'b0;
        chk("to_late_discard", 32'(dbg_rsp_valid), 32'h0);
        chk("to_idle_rmask", 32'(sram_rmask), 32'h0);

        // reset in the middle of a debug read
        tick();
        dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 32'h0000_0500;
        tick();
        dbg_req_valid = 1'b0;
        chk("rr_rmask", 32'(sram_rmask), 32'hF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_rmask_clr", 32'(sram_rmask), 32'h0);
        chk("rr_no_rsp", 32'(dbg_rsp_valid), 32'h0);
        dbg_req_valid = 1'b1; dbg_req_we = 1'b1;
        dbg_req_addr = 32'h0000_0600; dbg_req_wdata = 32'h600D_F00D;
        #1;
        chk("rr_ready", 32'(dbg_req_ready), 32'h1);
        tick();
        dbg_req_valid = 1'b0;
        chk("rr_wdata", sram_wdata, 32'h600D_F00D);
        sram_resp = 1'b1;
        tick();
        sram_resp = 1'b0;
        chk("rr_rsp_valid", 32'(dbg_rsp_valid), 32'h1);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
